// File: rtl/operand_fetch_unit.sv
// Operand fetch / 6502 effective-address sequencer feeding the ALU.
// Reads operand, pointer and data bytes over a single-outstanding byte read port.
package operand_fetch_pkg;
  typedef enum logic [3:0] {
    ALU_BYPASS_A = 4'd0,
    ALU_ADD      = 4'd1,
    ALU_SUB      = 4'd2,
    ALU_AND      = 4'd3,
    ALU_OR       = 4'd4,
    ALU_XOR      = 4'd5,
    ALU_CMP      = 4'd6,
    ALU_BYPASS_B = 4'd7
  } alu_op_t;
endpackage

module operand_fetch_unit
  import operand_fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES  = 255,
  parameter int unsigned EMULATE_JMP_BUG = 1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        start_i,
  output logic        ready_o,
  input  logic [3:0]  addr_mode_i,
  input  logic        need_data_i,
  input  logic [15:0] pc_i,
  input  logic [7:0]  idx_x_i,
  input  logic [7:0]  idx_y_i,
  input  logic [15:0] reg_val_i,
  input  alu_op_t     alu_op_i,
  output logic        mem_req_o,
  output logic [15:0] mem_addr_o,
  input  logic [7:0]  mem_rdata_i,
  input  logic        mem_rvalid_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] op_a_o,
  output logic [15:0] op_b_o,
  output alu_op_t     alu_op_o,
  output logic [15:0] ea_o,
  output logic [1:0]  len_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OP_LO  = 3'd1,
    S_OP_HI  = 3'd2,
    S_PTR_LO = 3'd3,
    S_PTR_HI = 3'd4,
    S_DATA   = 3'd5,
    S_OUT    = 3'd6
  } state_e;

  localparam logic [3:0] M_IMM  = 4'd0, M_ZP   = 4'd1, M_ZPX  = 4'd2, M_ZPY = 4'd3,
                         M_ABSX = 4'd5, M_ABSY = 4'd6, M_INDX = 4'd7, M_INDY = 4'd8,
                         M_ABS  = 4'd4, M_IND  = 4'd9;
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  state_e      state_q, state_d;
  logic [3:0]  mode_q, mode_d;
  logic        need_q, need_d;
  logic [15:0] pc_q, pc_d, op_a_q, op_a_d, ptr_addr_q, ptr_addr_d;
  logic [7:0]  x_q, x_d, y_q, y_d, lo_q, lo_d, ptr_lo_q, ptr_lo_d;
  alu_op_t     alu_op_q, alu_op_d;
  logic [15:0] ea_q, ea_d, op_b_q, op_b_d, mem_addr_q, mem_addr_d, wd_q, wd_d;
  logic [1:0]  len_q, len_d;
  logic        err_q, err_d, mem_req_q, mem_req_d;
  logic        done_s, ea_done_s;
  logic [15:0] ea_val_s, ptr_s;

  function automatic logic [1:0] mode_len(input logic [3:0] mode);
    case (mode)
      M_IMM, M_ZP, M_ZPX, M_ZPY, M_INDX, M_INDY: mode_len = 2'd1;
      M_ABS, M_ABSX, M_ABSY, M_IND:               mode_len = 2'd2;
      default:                                    mode_len = 2'd0;
    endcase
  endfunction

  // Zero-page pointers always wrap within the page; JMP (ind) does too when the bug is emulated.
  function automatic logic [15:0] ptr_hi_addr(input logic [15:0] p, input logic is_ind);
    if (is_ind && EMULATE_JMP_BUG == 32'd0) begin
      ptr_hi_addr = p + 16'd1;
    end else begin
      ptr_hi_addr = {p[15:8], p[7:0] + 8'd1};
    end
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      mode_q     <= 4'd0;
      need_q     <= 1'b0;
      pc_q       <= 16'h0000;
      x_q        <= 8'h00;
      y_q        <= 8'h00;
      op_a_q     <= 16'h0000;
      alu_op_q   <= ALU_BYPASS_A;
      lo_q       <= 8'h00;
      ptr_lo_q   <= 8'h00;
      ptr_addr_q <= 16'h0000;
      ea_q       <= 16'h0000;
      op_b_q     <= 16'h0000;
      len_q      <= 2'd0;
      err_q      <= 1'b0;
      wd_q       <= 16'h0000;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      need_q     <= need_d;
      pc_q       <= pc_d;
      x_q        <= x_d;
      y_q        <= y_d;
      op_a_q     <= op_a_d;
      alu_op_q   <= alu_op_d;
      lo_q       <= lo_d;
      ptr_lo_q   <= ptr_lo_d;
      ptr_addr_q <= ptr_addr_d;
      ea_q       <= ea_d;
      op_b_q     <= op_b_d;
      len_q      <= len_d;
      err_q      <= err_d;
      wd_q       <= wd_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    need_d     = need_q;
    pc_d       = pc_q;
    x_d        = x_q;
    y_d        = y_q;
    op_a_d     = op_a_q;
    alu_op_d   = alu_op_q;
    lo_d       = lo_q;
    ptr_lo_d   = ptr_lo_q;
    ptr_addr_d = ptr_addr_q;
    ea_d       = ea_q;
    op_b_d     = op_b_q;
    len_d      = len_q;
    err_d      = err_q;
    wd_d       = wd_q;
    done_s     = mem_req_q && mem_rvalid_i;
    ea_done_s  = 1'b0;
    ea_val_s   = 16'h0000;
    ptr_s      = {mem_rdata_i, ptr_lo_q};

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d   = addr_mode_i;
          need_d   = need_data_i;
          pc_d     = pc_i;
          x_d      = idx_x_i;
          y_d      = idx_y_i;
          op_a_d   = reg_val_i;
          alu_op_d = alu_op_i;
          len_d    = mode_len(addr_mode_i);
          if (addr_mode_i > M_IND) begin
            err_d   = 1'b1;
            state_d = S_OUT;
          end else begin
            state_d = S_OP_LO;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OP_LO: begin
        if (done_s) begin
          lo_d = mem_rdata_i;
          case (mode_q)
            M_IMM: begin
              ea_d    = pc_q;
              op_b_d  = {8'h00, mem_rdata_i};
              state_d = S_OUT;
            end
            M_ZP:  begin ea_done_s = 1'b1; ea_val_s = {8'h00, mem_rdata_i}; end
            M_ZPX: begin ea_done_s = 1'b1; ea_val_s = {8'h00, mem_rdata_i + x_q}; end
            M_ZPY: begin ea_done_s = 1'b1; ea_val_s = {8'h00, mem_rdata_i + y_q}; end
            M_INDX: begin
              ptr_addr_d = {8'h00, mem_rdata_i + x_q};
              state_d    = S_PTR_LO;
            end
            M_INDY: begin
              ptr_addr_d = {8'h00, mem_rdata_i};
              state_d    = S_PTR_LO;
            end
            default: state_d = S_OP_HI;
          endcase
        end else begin
          state_d = S_OP_LO;
        end
      end
      S_OP_HI: begin
        if (done_s) begin
          case (mode_q)
            M_ABS:  begin ea_done_s = 1'b1; ea_val_s = {mem_rdata_i, lo_q}; end
            M_ABSX: begin ea_done_s = 1'b1; ea_val_s = {mem_rdata_i, lo_q} + {8'h00, x_q}; end
            M_ABSY: begin ea_done_s = 1'b1; ea_val_s = {mem_rdata_i, lo_q} + {8'h00, y_q}; end
            default: begin
              ptr_addr_d = {mem_rdata_i, lo_q};
              state_d    = S_PTR_LO;
            end
          endcase
        end else begin
          state_d = S_OP_HI;
        end
      end
      S_PTR_LO: begin
        if (done_s) begin
          ptr_lo_d = mem_rdata_i;
          state_d  = S_PTR_HI;
        end else begin
          state_d = S_PTR_LO;
        end
      end
      S_PTR_HI: begin
        if (done_s) begin
          ea_done_s = 1'b1;
          ea_val_s  = (mode_q == M_INDY) ? ptr_s + {8'h00, y_q} : ptr_s;
        end else begin
          state_d = S_PTR_HI;
        end
      end
      S_DATA: begin
        if (done_s) begin
          op_b_d  = {8'h00, mem_rdata_i};
          state_d = S_OUT;
        end else begin
          state_d = S_DATA;
        end
      end
      S_OUT: begin
        if (out_ready_i) begin
          op_a_d   = 16'h0000;
          op_b_d   = 16'h0000;
          ea_d     = 16'h0000;
          len_d    = 2'd0;
          err_d    = 1'b0;
          alu_op_d = ALU_BYPASS_A;
          state_d  = S_IDLE;
        end else begin
          state_d = S_OUT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Once the EA is known, IND never fetches data; everything else does when asked.
    if (ea_done_s) begin
      ea_d = ea_val_s;
      if (need_q && mode_q != M_IND) begin
        state_d = S_DATA;
      end else begin
        op_b_d  = ea_val_s;
        state_d = S_OUT;
      end
    end else begin
      ea_d = ea_d;
    end

    if (TIMEOUT_CYCLES != 32'd0 && mem_req_q && !mem_rvalid_i) begin
      if (wd_q == WD_LAST) begin
        err_d   = 1'b1;
        wd_d    = 16'h0000;
        state_d = S_OUT;
      end else begin
        wd_d = wd_q + 16'd1;
      end
    end else begin
      wd_d = 16'h0000;
    end

    case (state_d)
      S_OP_LO:  mem_addr_d = pc_d;
      S_OP_HI:  mem_addr_d = pc_d + 16'd1;
      S_PTR_LO: mem_addr_d = ptr_addr_d;
      S_PTR_HI: mem_addr_d = ptr_hi_addr(ptr_addr_d, mode_d == M_IND);
      S_DATA:   mem_addr_d = ea_d;
      default:  mem_addr_d = 16'h0000;
    endcase
    mem_req_d = (state_d == S_OP_LO) || (state_d == S_OP_HI) || (state_d == S_PTR_LO) ||
                (state_d == S_PTR_HI) || (state_d == S_DATA);
  end

  always_comb begin
    ready_o     = (state_q == S_IDLE);
    out_valid_o = (state_q == S_OUT);
    mem_req_o   = mem_req_q;
    mem_addr_o  = mem_addr_q;
    op_a_o      = op_a_q;
    op_b_o      = op_b_q;
    alu_op_o    = alu_op_q;
    ea_o        = ea_q;
    len_o       = len_q;
    err_o       = err_q;
  end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Randomized bench for operand_fetch_unit: a byte-memory responder with random latency
// and a reference model deriving the expected access list and payload per instruction.
module tb_operand_fetch_unit;
  import operand_fetch_pkg::*;

  localparam int TO  = 8;
  localparam int EMU = 1;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        start_i;
  logic        ready_o;
  logic [3:0]  addr_mode_i;
  logic        need_data_i;
  logic [15:0] pc_i;
  logic [7:0]  idx_x_i, idx_y_i;
  logic [15:0] reg_val_i;
  alu_op_t     alu_op_i;
  logic        mem_req_o;
  logic [15:0] mem_addr_o;
  logic [7:0]  mem_rdata_i;
  logic        mem_rvalid_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] op_a_o, op_b_o, ea_o;
  alu_op_t     alu_op_o;
  logic [1:0]  len_o;
  logic        err_o;

  operand_fetch_unit #(.TIMEOUT_CYCLES(TO), .EMULATE_JMP_BUG(EMU)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .ready_o(ready_o),
    .addr_mode_i(addr_mode_i), .need_data_i(need_data_i), .pc_i(pc_i),
    .idx_x_i(idx_x_i), .idx_y_i(idx_y_i), .reg_val_i(reg_val_i), .alu_op_i(alu_op_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .mem_rvalid_i(mem_rvalid_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .op_a_o(op_a_o), .op_b_o(op_b_o), .alu_op_o(alu_op_o), .ea_o(ea_o),
    .len_o(len_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  logic [7:0] mem [0:65535];
  int got_addr[$];
  int exp_addr[$];
  int n_checks = 0;
  int n_errors = 0;
  int dly_lo = 0, dly_hi = 3;
  bit resp_en = 1'b1;
  bit force_rv = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory responder: random latency, logs every completed address.
  initial begin
    int dly;
    dly = 0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 8'h00;
    forever begin
      @(negedge clk_i);
      if (!resp_en) begin
        mem_rvalid_i = force_rv;
      end else if (!mem_req_o || mem_rvalid_i) begin
        mem_rvalid_i = 1'b0;
        dly = int'($urandom_range(dly_hi, dly_lo));
      end else if (dly == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem[mem_addr_o];
        got_addr.push_back(int'(mem_addr_o));
      end else begin
        dly--;
      end
    end
  end

  task automatic model(input logic [3:0] mode, input logic need, input logic [15:0] pc,
                       input logic [7:0] x, input logic [7:0] y,
                       output int opb, output int ea, output int len, output int err);
    int b, h, p, t, ha;
    exp_addr.delete();
    opb = 0; ea = 0; len = 0; err = 0;
    if (mode > 4'd9) begin
      err = 1;
      return;
    end
    b = int'(mem[pc]);
    exp_addr.push_back(int'(pc));
    len = 1;
    case (mode)
      4'd0: ea = int'(pc);
      4'd1: ea = b;
      4'd2: ea = (b + int'(x)) % 256;
      4'd3: ea = (b + int'(y)) % 256;
      4'd7: begin
        t = (b + int'(x)) % 256;
        exp_addr.push_back(t);
        exp_addr.push_back((t + 1) % 256);
        ea = int'(mem[t]) + 256 * int'(mem[(t + 1) % 256]);
      end
      4'd8: begin
        exp_addr.push_back(b);
        exp_addr.push_back((b + 1) % 256);
        ea = (int'(mem[b]) + 256 * int'(mem[(b + 1) % 256]) + int'(y)) % 65536;
      end
      default: begin
        len = 2;
        h = int'(mem[(int'(pc) + 1) % 65536]);
        exp_addr.push_back((int'(pc) + 1) % 65536);
        p = h * 256 + b;
        if (mode == 4'd4) ea = p;
        else if (mode == 4'd5) ea = (p + int'(x)) % 65536;
        else if (mode == 4'd6) ea = (p + int'(y)) % 65536;
        else begin
          ha = (EMU != 0) ? (p / 256) * 256 + (p + 1) % 256 : (p + 1) % 65536;
          exp_addr.push_back(p);
          exp_addr.push_back(ha);
          ea = int'(mem[p]) + 256 * int'(mem[ha]);
        end
      end
    endcase
    if (mode == 4'd0) opb = b;
    else if (need && mode != 4'd9) begin
      exp_addr.push_back(ea);
      opb = int'(mem[ea]);
    end else opb = ea;
  endtask

  task automatic run_txn(input logic [3:0] mode, input logic need, input logic [15:0] pc,
                         input logic [7:0] x, input logic [7:0] y, input alu_op_t op,
                         input int hold);
    int eopb, eea, elen, eerr, n, req_cnt;
    logic [15:0] rv, p_addr;
    logic p_req;
    model(mode, need, pc, x, y, eopb, eea, elen, eerr);
    rv = 16'($urandom);
    @(negedge clk_i);
    check_val("ready_before_start", ready_o, 1);
    got_addr.delete();
    addr_mode_i = mode; need_data_i = need; pc_i = pc; idx_x_i = x; idx_y_i = y;
    reg_val_i = rv; alu_op_i = op; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    addr_mode_i = 4'($urandom); pc_i = 16'($urandom); idx_x_i = 8'($urandom);
    idx_y_i = 8'($urandom); need_data_i = 1'($urandom); reg_val_i = 16'($urandom);
    n = 0; req_cnt = 0; p_req = 1'b0; p_addr = 16'h0000;
    while (!out_valid_o && n < 400) begin
      @(negedge clk_i); #1;
      if (p_req && mem_req_o) check_val("addr_stable", mem_addr_o, p_addr);
      p_req  = mem_req_o && !mem_rvalid_i;
      p_addr = mem_addr_o;
      if (mem_req_o) req_cnt++;
      start_i = 1'($urandom);
      n++;
    end
    start_i = 1'b0;
    check_val("out_valid", out_valid_o, 1);
    check_val("n_access", got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++)
      check_val("access_addr", got_addr[i], exp_addr[i]);
    if (eerr != 0) check_val("no_mem_req", req_cnt, 0);
    check_val("op_a", op_a_o, rv);
    check_val("op_b", op_b_o, eopb);
    check_val("ea", ea_o, eea);
    check_val("len", len_o, elen);
    check_val("err", err_o, eerr);
    check_val("alu_op", 32'(alu_op_o), 32'(op));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i); #1;
      check_val("hold_valid", out_valid_o, 1);
      check_val("hold_op_b", op_b_o, eopb);
      check_val("hold_ea", ea_o, eea);
      check_val("hold_mem_req", mem_req_o, 0);
    end
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
    check_val("post_ready", ready_o, 1);
    check_val("post_valid", out_valid_o, 0);
    check_val("post_err", err_o, 0);
    check_val("post_op_b", op_b_o, 0);
  endtask

  initial begin
    int n, req_cnt;
    logic [3:0] m;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rstn_i = 1'b0; start_i = 1'b0; out_ready_i = 1'b0;
    addr_mode_i = 4'd0; need_data_i = 1'b0; pc_i = 16'h0000; idx_x_i = 8'h00;
    idx_y_i = 8'h00; reg_val_i = 16'h0000; alu_op_i = ALU_ADD;
    repeat (3) @(negedge clk_i);
    check_val("rst_ready", ready_o, 1);
    check_val("rst_valid", out_valid_o, 0);
    check_val("rst_req", mem_req_o, 0);
    check_val("rst_op_a", op_a_o, 0);
    check_val("rst_ea", ea_o, 0);
    check_val("rst_err", err_o, 0);
    check_val("rst_alu_op", 32'(alu_op_o), 32'(ALU_BYPASS_A));
    rstn_i = 1'b1;

    // Directed cases
    mem[16'h0200] = 8'hF0; mem[16'h0010] = 8'h5A;
    run_txn(4'd2, 1'b1, 16'h0200, 8'h20, 8'h00, ALU_ADD, 1);
    mem[16'h0300] = 8'hFF; mem[16'h0301] = 8'h12;
    run_txn(4'd5, 1'b0, 16'h0300, 8'h01, 8'h00, ALU_SUB, 0);
    mem[16'h0500] = 8'hFF; mem[16'h00FF] = 8'h00; mem[16'h0000] = 8'h80;
    run_txn(4'd8, 1'b1, 16'h0500, 8'h00, 8'h10, ALU_OR, 0);
    mem[16'h0600] = 8'hFF; mem[16'h0601] = 8'h10;
    run_txn(4'd9, 1'b1, 16'h0600, 8'h00, 8'h00, ALU_BYPASS_B, 0);
    run_txn(4'd4, 1'b1, 16'hFFFF, 8'h00, 8'h00, ALU_AND, 0);
    run_txn(4'd12, 1'b1, 16'h0700, 8'h00, 8'h00, ALU_XOR, 1);
    dly_lo = 5; dly_hi = 5;
    run_txn(4'd6, 1'b1, 16'h0800, 8'h00, 8'hFF, ALU_CMP, 3);
    dly_lo = 0; dly_hi = 3;

    for (int k = 0; k < 200; k++) begin
      m = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      run_txn(m, 1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
              alu_op_t'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
    end

    // Watchdog: memory never answers
    @(negedge clk_i);
    resp_en = 1'b0; force_rv = 1'b0;
    addr_mode_i = 4'd1; need_data_i = 1'b1; pc_i = 16'h0900; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    n = 0; req_cnt = 0;
    while (!out_valid_o && n < 50) begin
      @(negedge clk_i); #1;
      if (mem_req_o) req_cnt++;
      n++;
    end
    check_val("wd_valid", out_valid_o, 1);
    check_val("wd_req_cycles", req_cnt, TO);
    check_val("wd_err", err_o, 1);
    check_val("wd_req_dropped", mem_req_o, 0);
    check_val("wd_ea", ea_o, 0);
    check_val("wd_len", len_o, 1);
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
    check_val("wd_err_clear", err_o, 0);
    resp_en = 1'b1;

    // Reset while waiting for the INDX pointer low byte
    mem[16'h0400] = 8'h10;
    dly_lo = 3; dly_hi = 3;
    @(negedge clk_i);
    addr_mode_i = 4'd7; need_data_i = 1'b1; pc_i = 16'h0400; idx_x_i = 8'h05; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    n = 0;
    while (!(mem_req_o && mem_addr_o == 16'h0015) && n < 50) begin
      @(negedge clk_i); #1;
      n++;
    end
    check_val("reach_ptr_lo", mem_addr_o, 16'h0015);
    resp_en = 1'b0; force_rv = 1'b0; rstn_i = 1'b0;
    @(negedge clk_i); #1;
    check_val("mid_rst_ready", ready_o, 1);
    check_val("mid_rst_req", mem_req_o, 0);
    force_rv = 1'b1; rstn_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    check_val("stray_ready", ready_o, 1);
    check_val("stray_req", mem_req_o, 0);
    check_val("stray_valid", out_valid_o, 0);
    force_rv = 1'b0; resp_en = 1'b1;
    dly_lo = 0; dly_hi = 3;
    run_txn(4'd0, 1'b1, 16'h1234, 8'h00, 8'h00, ALU_ADD, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
